// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding and
// conversions between requester index and one-hot vectors.
package bram_arb_pkg;

    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic logic [MAX_NREQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the requester-side handshake and the BRAM-side port. The arbiter
// takes the slave view; clients plus the BRAM model take the master view.
interface bram_port_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_we;
    logic [NREQ-1:0]            req_lock;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_rdata;
    logic                       bram_wr_ea;
    logic [ADDR_WIDTH-1:0]      bram_addr;
    logic [DATA_WIDTH-1:0]      bram_din;
    logic [DATA_WIDTH-1:0]      bram_dout;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, bram_dout,
        output req_ready, rsp_valid, rsp_rdata, bram_wr_ea, bram_addr, bram_din
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, bram_dout,
        input  req_ready, rsp_valid, rsp_rdata, bram_wr_ea, bram_addr, bram_din
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester found searching from
// last_grant+1 upward (wrapping) wins.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    // NOTE: every variable written here gets a default first; without it an
    // unassigned path would infer a latch.
    always_comb begin
        gnt  = '0;
        cand = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant) + off) % NREQ);
            if (req[cand]) begin
                gnt = NREQ'(idx_to_onehot(MAX_IDX_W'(cand)));
            end
        end
    end

    assign gnt_idx = IDX_W'(onehot_to_idx(MAX_NREQ'(gnt)));
    assign gnt_any = |req;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM among NREQ valid/ready requesters with
// round-robin arbitration, bounded burst locking and read-data return.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    bram_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, burst_inc;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;

    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_we_q, cmd_we_d;
    logic                  cmd_rd_q, cmd_rd_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [IDX_W-1:0]      cmd_id_q, cmd_id_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic [IDX_W-1:0]      rsp_id_q, rsp_id_d;
    logic                  rsp_fire;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    assign burst_inc = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q : burst_cnt_q + 1'b1;

    // Grant/FSM: ready is a function of req_valid, last_grant and state only.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        grant        = '0;
        sel_idx      = arb_idx;
        case (state_q)
            ST_ARB: begin
                grant = arb_gnt;
                if (arb_any) begin
                    last_grant_d = arb_idx;
                    if (bus.req_lock[arb_idx] && MAX_BURST > 1) begin
                        state_d     = ST_LOCK;
                        owner_d     = arb_idx;
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
            ST_LOCK: begin
                sel_idx = owner_q;
                if (bus.req_valid[owner_q]) begin
                    grant       = NREQ'(idx_to_onehot(MAX_IDX_W'(owner_q)));
                    burst_cnt_d = burst_inc;
                    if (!bus.req_lock[owner_q] || burst_inc == CNT_W'(MAX_BURST)) begin
                        state_d      = ST_ARB;
                        last_grant_d = owner_q;
                    end
                end else begin
                    // Owner went idle: the lock is forfeited and nobody is granted.
                    state_d      = ST_ARB;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = ST_ARB;
        endcase
        if (!rstn) begin
            grant = '0;
        end
    end

    assign accept = |grant;

    always_comb begin
        cmd_valid_d = accept;
        cmd_we_d    = cmd_we_q;
        cmd_rd_d    = 1'b0;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_id_d    = cmd_id_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && sel_idx == IDX_W'(i)) begin
                cmd_we_d    = bus.req_we[i];
                cmd_rd_d    = ~bus.req_we[i];
                cmd_addr_d  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_wdata_d = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                cmd_id_d    = IDX_W'(i);
            end
        end
        rsp_pend_d = cmd_rd_q;
        rsp_id_d   = cmd_id_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_ARB;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
            burst_cnt_q  <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_rd_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_id_q     <= '0;
            rsp_pend_q   <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_we_q     <= cmd_we_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_id_q     <= cmd_id_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // Outputs are masked while rstn is low so in-flight work never escapes.
    assign rsp_fire       = rstn & rsp_pend_q;
    assign bus.req_ready  = grant;
    assign bus.bram_wr_ea = rstn & cmd_valid_q & cmd_we_q;
    assign bus.bram_addr  = cmd_addr_q;
    assign bus.bram_din   = cmd_wdata_q;
    assign bus.rsp_valid  = rsp_fire ? NREQ'(idx_to_onehot(MAX_IDX_W'(rsp_id_q))) : '0;
    assign bus.rsp_rdata  = rsp_fire ? bus.bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a behavioural model of arbitration, locking and memory contents.
module tb_bram_port_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 4;
    localparam int AW        = 3;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rstn;

    bram_port_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_port_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic [NREQ-1:0] t_valid, t_we, t_lock;
    logic [AW-1:0]   t_addr  [NREQ];
    logic [DW-1:0]   t_wdata [NREQ];

    assign bus.req_valid = t_valid;
    assign bus.req_we    = t_we;
    assign bus.req_lock  = t_lock;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign bus.req_addr[gi*AW +: AW]  = t_addr[gi];
        assign bus.req_wdata[gi*DW +: DW] = t_wdata[gi];
    end

    // BRAM model: registered read, write on the enable
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (bus.bram_wr_ea) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr];
    end

    // Reference model state
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          rspq[$];
    logic [DW-1:0] shadow [2**AW];
    int            m_last   = NREQ - 1;
    bit            m_locked = 1'b0;
    int            m_owner  = 0;
    int            m_cnt    = 0;
    bit            pend_v   = 1'b0;
    bit            pend_we  = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    int            cyc      = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] obs_ready, obs_rsp_valid;
    logic [DW-1:0]   obs_rdata, obs_din;
    logic [AW-1:0]   obs_addr;
    logic            obs_wr_ea;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        int c;
        if (m_locked) return t_valid[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (t_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_accept(input int g);
        if (m_locked) begin
            m_cnt++;
            if (!t_lock[g] || m_cnt >= MAX_BURST) begin
                m_locked = 1'b0;
                m_last   = g;
            end
        end else begin
            m_last = g;
            if (t_lock[g] && MAX_BURST > 1) begin
                m_locked = 1'b1;
                m_owner  = g;
                m_cnt    = 1;
            end
        end
    endfunction

    // One clock cycle: entered just after a negedge with inputs already driven.
    task automatic step();
        int              g;
        logic [NREQ-1:0] e_rdy, e_rsp;
        logic [DW-1:0]   e_rdata;
        logic            e_wr;
        rsp_t            r;
        #1;
        obs_ready     = bus.req_ready;
        obs_rsp_valid = bus.rsp_valid;
        obs_rdata     = bus.rsp_rdata;
        obs_wr_ea     = bus.bram_wr_ea;
        obs_addr      = bus.bram_addr;
        obs_din       = bus.bram_din;
        e_rdy = '0; e_rsp = '0; e_rdata = '0; e_wr = 1'b0; g = -1;
        if (rstn) begin
            g = model_grant();
            if (g >= 0) e_rdy = NREQ'(1) << g;
            if (rspq.size() > 0 && rspq[0].due == cyc) begin
                e_rsp   = NREQ'(1) << rspq[0].id;
                e_rdata = rspq[0].data;
                void'(rspq.pop_front());
            end
            e_wr = pend_v && pend_we;
        end
        check("req_ready", obs_ready, e_rdy);
        check("rsp_valid", obs_rsp_valid, e_rsp);
        check("rsp_rdata", obs_rdata, e_rdata);
        check("bram_wr_ea", obs_wr_ea, e_wr);
        if (rstn && pend_v) begin
            check("bram_addr", obs_addr, pend_addr);
            if (pend_we) check("bram_din", obs_din, pend_data);
        end
        pend_v = 1'b0;
        if (rstn && g >= 0) begin
            pend_v    = 1'b1;
            pend_we   = t_we[g];
            pend_addr = t_addr[g];
            pend_data = t_wdata[g];
            if (t_we[g]) begin
                shadow[t_addr[g]] = t_wdata[g];
            end else begin
                r.id = g; r.data = shadow[t_addr[g]]; r.due = cyc + 2;
                rspq.push_back(r);
            end
            model_accept(g);
        end else if (rstn && m_locked) begin
            m_locked = 1'b0;
            m_last   = m_owner;
        end
        if (!rstn) begin
            m_last = NREQ - 1; m_locked = 1'b0; m_cnt = 0;
            rspq.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input int a, input int d);
        t_valid[i]  = v;
        t_we[i]     = we;
        t_lock[i]   = lk;
        t_addr[i]   = AW'(a);
        t_wdata[i]  = DW'(d);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        idle_all();
        rstn = 1'b0;
        repeat (n) step();
        rstn = 1'b1;
    endtask

    int lock_seq [6] = '{2, 2, 2, 2, 3, 0};
    int drop_seq [4] = '{1, 1, -1, 2};

    initial begin
        for (int a = 0; a < 2**AW; a++) begin
            mem[a]    = '0;
            shadow[a] = '0;
        end
        rstn = 1'b0;
        idle_all();
        @(negedge clk);

        // Reset held with every requester valid
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, i, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_ready", obs_ready, 0);
            check("reset_rsp_valid", obs_rsp_valid, 0);
            check("reset_wr_ea", obs_wr_ea, 0);
        end
        rstn = 1'b1;
        step();
        check("first_grant", obs_ready, 4'b0001);
        check("reset_addr", obs_addr, 0);
        check("reset_din", obs_din, 0);
        idle_all();
        repeat (3) step();

        // Single writer then reader on requester 0
        set_req(0, 1, 1, 0, 3, 4'hA);
        step();
        check("wr_grant", obs_ready, 4'b0001);
        set_req(0, 1, 0, 0, 3, 0);
        step();
        check("wr_commit_ea", obs_wr_ea, 1);
        check("wr_commit_addr", obs_addr, 3);
        idle_all();
        step();
        check("rd_not_early", obs_rsp_valid, 0);
        step();
        check("rd_rsp_valid", obs_rsp_valid, 4'b0001);
        check("rd_rsp_data", obs_rdata, 4'hA);
        step();

        // Round-robin with all four valid
        do_reset(1);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, $urandom_range(0, 7), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_order", obs_ready, 32'(4'b0001 << (k % 4)));
        end
        idle_all();
        repeat (3) step();

        // Lock bound on requester 2
        do_reset(1);
        set_req(2, 1, 0, 1, 5, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("lock_bound", obs_ready, 32'(4'b0001 << lock_seq[k]));
            if (k == 0) begin
                set_req(0, 1, 0, 0, 1, 0);
                set_req(1, 1, 0, 0, 2, 0);
                set_req(3, 1, 0, 0, 4, 0);
            end
        end
        idle_all();
        repeat (3) step();

        // Lock drop by requester 1
        do_reset(1);
        set_req(1, 1, 0, 1, 6, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("lock_drop", obs_ready, (drop_seq[k] < 0) ? 0 : 32'(4'b0001 << drop_seq[k]));
            if (k == 0) begin
                set_req(0, 1, 0, 0, 0, 0);
                set_req(2, 1, 0, 0, 2, 0);
                set_req(3, 1, 0, 0, 3, 0);
            end
            if (k == 1) t_valid[1] = 1'b0;
            if (k == 2) t_valid[1] = 1'b1;
        end
        idle_all();
        repeat (3) step();

        // Reset while two reads are in flight
        do_reset(1);
        set_req(0, 1, 0, 0, 1, 0);
        step();
        set_req(0, 1, 0, 0, 2, 0);
        step();
        idle_all();
        rstn = 1'b0;
        step();
        check("midreset_rsp", obs_rsp_valid, 0);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("midreset_rsp", obs_rsp_valid, 0);
            check("midreset_wr_ea", obs_wr_ea, 0);
        end

        // Random mixed traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 99) < 30, $urandom_range(0, 7), $urandom_range(0, 15));
            end
            step();
        end
        idle_all();
        repeat (4) step();
        check("drain_empty", rspq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
